// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed byte image and writes it word by word.
// Optional trailing XOR checksum is enabled with the LOADER_CHECKSUM_EN macro.
module program_loader #(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned FIRST_BYTE_MSB = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDR_WIDTH-1:0]   mem_in_addr,
  output logic [8*WORD_BYTES-1:0] mem_in_data,
  output logic                    mem_in_valid,
  input  logic                    mem_in_ready,
  input  logic                    restart,
  output logic                    load_completed,
  output logic                    load_error,
  output logic [31:0]             words_loaded
);

  localparam int unsigned DATA_W = 8 * WORD_BYTES;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CALC_W = 72;
  localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(3);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_BYTES - 1);
  localparam logic [CALC_W-1:0] REGION    = (CALC_W'(1) << ADDR_WIDTH) - CALC_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_HDR     = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK   = 3'd3,
`endif
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = S_CHECK;
`else
  localparam state_t AFTER_PAYLOAD = S_DONE;
`endif

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  byte_cnt;
  logic [31:0]       word_count;
  logic [31:0]       n_full;
  logic [DATA_W-1:0] word_shift;
  logic              in_fire;
  logic              mem_fire;
  logic              hdr_last;
  logic              word_last;
  logic              oversize;
  logic              last_word;
  logic              in_ready_d;
  logic              mem_valid_d;
  logic              done_d;
  logic              err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign in_fire   = in_valid && in_ready;
  assign mem_fire  = mem_in_valid && mem_in_ready;
  assign hdr_last  = (byte_cnt == HDR_LAST);
  assign word_last = (byte_cnt == WORD_LAST);
  // Header is little-endian: each new byte enters at the top and the first byte ends in [7:0].
  assign n_full    = {in_data, word_count[31:8]};
  assign oversize  = (CALC_W'(n_full) * CALC_W'(WORD_BYTES)) > REGION;
  assign last_word = (33'(words_loaded) + 33'd1) >= 33'(word_count);
  assign word_shift = (FIRST_BYTE_MSB != 0)
                    ? ((mem_in_data << 8) | DATA_W'(in_data))
                    : ((mem_in_data >> 8) | (DATA_W'(in_data) << (DATA_W - 8)));

  // State register plus registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_HDR;
      in_ready       <= 1'b0;
      mem_in_valid   <= 1'b0;
      load_completed <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      state          <= state_next;
      in_ready       <= in_ready_d;
      mem_in_valid   <= mem_valid_d;
      load_completed <= done_d;
      load_error     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_HDR: begin
        if (in_fire && hdr_last) begin
          if (oversize)         state_next = S_ERROR;
          else if (n_full == 0) state_next = AFTER_PAYLOAD;
          else                  state_next = S_COLLECT;
        end
      end
      S_COLLECT: if (in_fire && word_last) state_next = S_WRITE;
      S_WRITE: begin
        if (mem_fire) state_next = last_word ? AFTER_PAYLOAD : S_COLLECT;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (in_fire) state_next = (in_data == csum) ? S_DONE : S_ERROR;
`endif
      S_DONE:  if (restart) state_next = S_HDR;
      S_ERROR: if (restart) state_next = S_HDR;
      default: state_next = S_HDR;
    endcase
  end

  // Output decode; ERROR keeps accepting so the host never stalls.
  always_comb begin
    in_ready_d  = 1'b0;
    mem_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_next)
      S_HDR, S_COLLECT: in_ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:          in_ready_d = 1'b1;
`endif
      S_WRITE:          mem_valid_d = 1'b1;
      S_DONE:           done_d = 1'b1;
      S_ERROR: begin
        err_d      = 1'b1;
        in_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: header count, word assembly, address and progress counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt     <= '0;
      word_count   <= '0;
      mem_in_data  <= '0;
      mem_in_addr  <= ADDR_WIDTH'(BASE_ADDR);
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        S_HDR: begin
          if (in_fire) begin
            word_count <= n_full;
            byte_cnt   <= hdr_last ? '0 : byte_cnt + CNT_W'(1);
          end
        end
        S_COLLECT: begin
          if (in_fire) begin
            mem_in_data <= word_shift;
            byte_cnt    <= word_last ? '0 : byte_cnt + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            csum        <= csum ^ in_data;
`endif
          end
        end
        S_WRITE: begin
          if (mem_fire) begin
            words_loaded <= words_loaded + 32'd1;
            mem_in_addr  <= mem_in_addr + ADDR_WIDTH'(WORD_BYTES);
          end
        end
        S_DONE, S_ERROR: begin
          if (restart) begin
            words_loaded <= '0;
            mem_in_addr  <= ADDR_WIDTH'(BASE_ADDR);
            byte_cnt     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter WORD_BYTES, default 4: bytes per memory word; legal range 1..8.
REQ-002 Parameter ADDR_WIDTH, default 16: width of mem_in_addr and of the addressable region.
REQ-003 Parameter BASE_ADDR, default 0: byte address of the first written word.
REQ-004 Parameter FIRST_BYTE_MSB, default 1: 1 = first received byte of a word lands in bits [8*WORD_BYTES-1 -: 8]; 0 = it lands in bits [7:0].
REQ-005 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 in_data  input  8  byte stream from the host UART.
REQ-009 in_valid  input  1  in_data holds a byte.
REQ-010 in_ready  output  1  loader accepts the byte this cycle; transfer = in_valid && in_ready.
REQ-011 mem_in_addr  output  ADDR_WIDTH  byte address of the current word write.
REQ-012 mem_in_data  output  8*WORD_BYTES  assembled word.
REQ-013 mem_in_valid  output  1  write request pending.
REQ-014 mem_in_ready  input  1  memory accepts the write; transfer = mem_in_valid && mem_in_ready.
REQ-015 restart  input  1  single-cycle pulse; re-arms the loader from DONE or ERROR.
REQ-016 load_completed  output  1  image fully written; drives release of core/main-memory reset.
REQ-017 load_error  output  1  image rejected; sticky until restart or reset.
REQ-018 words_loaded  output  32  count of words whose write transfer completed.

Function
REQ-019 Stream format: 4-byte word count N (little-endian), N*WORD_BYTES payload bytes, then one checksum byte only when LOADER_CHECKSUM_EN is defined.
REQ-020 States: HDR, COLLECT, WRITE, CHECK, DONE, ERROR; reset state HDR.
REQ-021 HDR: in_ready=1; after the 4th header byte, go to COLLECT if N>0; if N=0, go to CHECK when checksum is enabled, else DONE.
REQ-022 HDR: if N*WORD_BYTES > 2^ADDR_WIDTH - BASE_ADDR, go to ERROR without issuing any write.
REQ-023 COLLECT: in_ready=1; shift bytes into the word per FIRST_BYTE_MSB; after byte WORD_BYTES, go to WRITE next cycle.
REQ-024 WRITE: in_ready=0, mem_in_valid=1; addr/data held stable until mem_in_ready is sampled high.
REQ-025 On the write transfer: words_loaded +1, address += WORD_BYTES; go to COLLECT if words_loaded+1 < N, else CHECK (checksum enabled) or DONE.
REQ-026 Minimum spacing between consecutive write requests is WORD_BYTES+1 cycles; no write-to-write bubble is added beyond this.
REQ-027 DONE: load_completed=1, in_ready=0; bytes offered in DONE are not consumed.
REQ-028 ERROR: load_error=1, load_completed=0, in_ready=1 and incoming bytes are discarded so the host never stalls.
REQ-029 restart in DONE or ERROR: next state HDR; words_loaded, address and checksum cleared; load_completed and load_error cleared.
REQ-030 restart is ignored in HDR, COLLECT, WRITE and CHECK.
REQ-031 Address arithmetic is modulo 2^ADDR_WIDTH; REQ-022 guarantees no wrap occurs for an accepted image.

Reset
REQ-032 While reset=0: state HDR, in_ready=0, mem_in_valid=0, mem_in_addr=BASE_ADDR, mem_in_data=0, load_completed=0, load_error=0, words_loaded=0.
REQ-033 Reset asserted mid-WRITE drops mem_in_valid immediately (asynchronously); the partial image is abandoned and no write is retried.
REQ-034 in_ready rises in the first clock edge after reset deasserts.

Configuration
REQ-035 Macro LOADER_CHECKSUM_EN defined: running XOR of all payload bytes is kept; in CHECK, one byte is accepted; equal -> DONE, unequal -> ERROR.
REQ-036 LOADER_CHECKSUM_EN undefined: no checksum register, no CHECK state; the last write transfer goes straight to DONE.

Verification
REQ-037 WORD_BYTES=4, FIRST_BYTE_MSB=1, stream 02 00 00 00 | 11 22 33 44 | 55 66 77 88 -> writes (0x0000,0x11223344), (0x0004,0x55667788), then load_completed=1, words_loaded=2.
REQ-038 Same stream with FIRST_BYTE_MSB=0 -> data 0x44332211 and 0x88776655.
REQ-039 mem_in_ready held low for 5 cycles during the first write -> mem_in_valid/addr/data stable for 5 cycles, in_ready=0 throughout, single write recorded.
REQ-040 Header 00 00 00 00 -> load_completed=1 with no mem_in_valid pulse (checksum off); with checksum on, trailer 00 -> DONE, trailer 01 -> ERROR.
REQ-041 ADDR_WIDTH=4, header N=5 (20 bytes > 16) -> load_error=1, zero writes; then restart pulse plus a valid N=1 image -> load_completed=1, load_error=0.
REQ-042 Reset asserted while mem_in_valid=1 -> mem_in_valid=0 in the same cycle, words_loaded=0, state HDR after release.
